// File: rtl/alsu_scheduler_pkg.sv
// rtl/alsu_scheduler_pkg.sv - shared types and constants for the ALSU scheduler
package alsu_scheduler_pkg;

    typedef enum logic [2:0] {
        OR        = 3'd0,
        XOR       = 3'd1,
        ADD       = 3'd2,
        MULT      = 3'd3,
        SHIFT     = 3'd4,
        ROTATE    = 3'd5,
        INVALID_6 = 3'd6,
        INVALID_7 = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t           opcode;
        logic signed [2:0] A;
        logic signed [2:0] B;
        logic              cin;
        logic              serial_in;
        logic              red_op_A;
        logic              red_op_B;
        logic              bypass_A;
        logic              bypass_B;
        logic              direction;
        logic [5:0]        seed;
        logic [2:0]        count;
    } alsu_cmd_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        OP    = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } sched_state_t;

    localparam opcode_t ALSU_IDLE_OPCODE = OR;
    localparam int      SEED_LEN_C       = 6;
    localparam int      ALSU_LAT_C       = 2;

    function automatic logic is_shift_op(input opcode_t op);
        return (op == SHIFT) || (op == ROTATE);
    endfunction

    // OR of zero operands with all flags clear keeps the ALSU output and leds at zero.
    function automatic alsu_cmd_t idle_cmd();
        alsu_cmd_t c;
        c        = '0;
        c.opcode = ALSU_IDLE_OPCODE;
        return c;
    endfunction

    function automatic logic [2:0] op_cycles(input alsu_cmd_t c);
        if (is_shift_op(c.opcode) && (c.count != 3'd0)) begin
            return c.count;
        end
        return 3'd1;
    endfunction

endpackage

// File: rtl/alsu_rr_arbiter.sv
// rtl/alsu_rr_arbiter.sv - two-way round-robin grant with pointer advanced on accept
module alsu_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic grant_valid,
    output logic grant_id
);

    logic ptr_q;

    always_comb begin
        grant_valid = arb_en && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            grant_id = ptr_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    // Pointer moves away from whoever was just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (grant_valid) begin
            ptr_q <= ~grant_id;
        end
    end

endmodule

// File: rtl/alsu_scheduler.sv
// rtl/alsu_scheduler.sv - shares one ALSU between two requesters and returns tagged responses
module alsu_scheduler
    import alsu_scheduler_pkg::*;
#(
    parameter int ALSU_LAT = ALSU_LAT_C,
    parameter int SEED_LEN = SEED_LEN_C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  alsu_cmd_t         req0_cmd,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  alsu_cmd_t         req1_cmd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic signed [5:0] rsp_out,
    output logic              rsp_err,
    output logic              busy,
    output logic signed [2:0] alsu_A,
    output logic signed [2:0] alsu_B,
    output logic              alsu_cin,
    output logic              alsu_serial_in,
    output logic              alsu_direction,
    output logic              alsu_red_op_A,
    output logic              alsu_red_op_B,
    output logic              alsu_bypass_A,
    output logic              alsu_bypass_B,
    output opcode_t           alsu_opcode,
    input  logic signed [5:0] alsu_out,
    input  logic [15:0]       alsu_leds
);

    sched_state_t state_q, state_d;
    alsu_cmd_t    cmd_q;
    alsu_cmd_t    drive;
    logic         id_q;
    logic [2:0]   cnt_q, cnt_d;
    logic [2:0]   seed_idx;
    logic [2:0]   op_len;
    logic         arb_en;
    logic         grant_valid;
    logic         grant_id;
    logic         capture;

    alsu_rr_arbiter u_arb (
        .clk         (clk),
        .rst         (rst),
        .arb_en      (arb_en),
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign req0_ready = grant_valid && !grant_id;
    assign req1_ready = grant_valid && grant_id;
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign seed_idx   = 3'(SEED_LEN - 1) - cnt_q;
    assign op_len     = op_cycles(cmd_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arb_en  = 1'b0;
        capture = 1'b0;
        drive   = idle_cmd();
        unique case (state_q)
            IDLE: begin
                arb_en = !rst;
                if (grant_valid) begin
                    cnt_d   = 3'd0;
                    state_d = is_shift_op(grant_id ? req1_cmd.opcode : req0_cmd.opcode) ? SEED : OP;
                end
            end
            SEED: begin
                // Left shifts MSB-first so the ALSU output register ends up holding seed.
                drive.opcode    = SHIFT;
                drive.direction = 1'b1;
                drive.serial_in = cmd_q.seed[seed_idx];
                if (cnt_q == 3'(SEED_LEN - 1)) begin
                    cnt_d   = 3'd0;
                    state_d = OP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            OP: begin
                drive = cmd_q;
                if (cnt_q == op_len - 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == 3'(ALSU_LAT - 1)) begin
                    capture = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            drive = idle_cmd();
        end
    end

    always_comb begin
        alsu_opcode    = drive.opcode;
        alsu_A         = drive.A;
        alsu_B         = drive.B;
        alsu_cin       = drive.cin;
        alsu_serial_in = drive.serial_in;
        alsu_direction = drive.direction;
        alsu_red_op_A  = drive.red_op_A;
        alsu_red_op_B  = drive.red_op_B;
        alsu_bypass_A  = drive.bypass_A;
        alsu_bypass_B  = drive.bypass_B;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            cmd_q   <= idle_cmd();
            id_q    <= 1'b0;
            rsp_id  <= 1'b0;
            rsp_out <= '0;
            rsp_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant_valid) begin
                cmd_q <= grant_id ? req1_cmd : req0_cmd;
                id_q  <= grant_id;
            end
            if (capture) begin
                rsp_out <= alsu_out;
                rsp_err <= |alsu_leds;
                rsp_id  <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_alsu_scheduler.sv
// tb/tb_alsu_scheduler.sv - scoreboard bench for alsu_scheduler with a behavioural ALSU
module tb_alsu_scheduler;
    import alsu_scheduler_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    alsu_cmd_t         req0_cmd = '0, req1_cmd = '0;
    logic              rsp_valid, rsp_id, rsp_err, busy;
    logic              rsp_ready = 1'b1;
    logic signed [5:0] rsp_out;
    logic signed [2:0] alsu_A, alsu_B;
    logic              alsu_cin, alsu_serial_in, alsu_direction;
    logic              alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    opcode_t           alsu_opcode;
    logic signed [5:0] alsu_out;
    logic [15:0]       alsu_leds;

    always #5 clk = ~clk;

    alsu_scheduler dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_err(rsp_err), .busy(busy),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_cin(alsu_cin),
        .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_opcode(alsu_opcode), .alsu_out(alsu_out), .alsu_leds(alsu_leds)
    );

    // Behavioural ALSU: input register then output register.
    opcode_t           m_op;
    logic signed [2:0] m_a, m_b;
    logic              m_cin, m_sin, m_ra, m_rb, m_ba, m_bb, m_dir;
    logic signed [5:0] m_ax, m_bx, m_next;
    logic              m_inv;

    always @* begin
        m_ax   = {{3{m_a[2]}}, m_a};
        m_bx   = {{3{m_b[2]}}, m_b};
        m_inv  = (m_op == INVALID_6) || (m_op == INVALID_7) ||
                 ((m_ra || m_rb) && (m_op != OR) && (m_op != XOR));
        m_next = '0;
        if (m_inv) m_next = '0;
        else if (m_ba) m_next = m_ax;
        else if (m_bb) m_next = m_bx;
        else begin
            case (m_op)
                OR:      m_next = m_ra ? {5'b0, |m_a} : (m_rb ? {5'b0, |m_b} : (m_ax | m_bx));
                XOR:     m_next = m_ra ? {5'b0, ^m_a} : (m_rb ? {5'b0, ^m_b} : (m_ax ^ m_bx));
                ADD:     m_next = m_ax + m_bx + {5'b0, m_cin};
                MULT:    m_next = m_ax * m_bx;
                SHIFT:   m_next = m_dir ? {alsu_out[4:0], m_sin} : {m_sin, alsu_out[5:1]};
                ROTATE:  m_next = m_dir ? {alsu_out[4:0], alsu_out[5]} : {alsu_out[0], alsu_out[5:1]};
                default: m_next = '0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_op <= OR; m_a <= '0; m_b <= '0;
            {m_cin, m_sin, m_ra, m_rb, m_ba, m_bb, m_dir} <= '0;
            alsu_out <= '0; alsu_leds <= '0;
        end else begin
            m_op <= alsu_opcode; m_a <= alsu_A; m_b <= alsu_B;
            m_cin <= alsu_cin; m_sin <= alsu_serial_in; m_dir <= alsu_direction;
            m_ra <= alsu_red_op_A; m_rb <= alsu_red_op_B;
            m_ba <= alsu_bypass_A; m_bb <= alsu_bypass_B;
            alsu_out  <= m_next;
            alsu_leds <= m_inv ? 16'hFFFF : 16'h0000;
        end
    end

    typedef struct {
        logic              id;
        logic signed [5:0] out;
        logic              err;
        int                cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic alsu_cmd_t mk(input opcode_t op, input int a, input int b, input bit cin,
                                     input bit sin, input bit ra, input bit rb, input bit ba,
                                     input bit bb, input bit dir, input logic [5:0] seed,
                                     input logic [2:0] count);
        alsu_cmd_t c;
        c.opcode = op;   c.A = 3'(a);     c.B = 3'(b);
        c.cin = cin;     c.serial_in = sin;
        c.red_op_A = ra; c.red_op_B = rb;
        c.bypass_A = ba; c.bypass_B = bb;
        c.direction = dir; c.seed = seed; c.count = count;
        return c;
    endfunction

    function automatic int exp_lat(input alsu_cmd_t c);
        if (c.opcode == SHIFT || c.opcode == ROTATE)
            return 1 + 6 + ((c.count == 0) ? 1 : int'(c.count)) + 2;
        return 4;
    endfunction

    task automatic issue(input bit port, input alsu_cmd_t c, input logic signed [5:0] eo,
                         input bit ee, input bit push);
        bit   got;
        exp_t e;
        @(posedge clk); #1;
        if (port) begin req1_cmd = c; req1_valid = 1'b1; end
        else      begin req0_cmd = c; req0_valid = 1'b1; end
        got = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) got = 1;
        end
        if (!got) check("grant_timeout", 0, 1);
        else if (push) begin
            e.id = port; e.out = eo; e.err = ee; e.cyc = cyc + exp_lat(c);
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 100 && (sb_q.size() != 0 || busy); t++) @(negedge clk);
        if (t >= 100) check("drain_timeout", 0, 1);
    endtask

    // Monitor: compare the scoreboard head on the first cycle of each response.
    initial begin
        exp_t e;
        bit   seen;
        seen = 0;
        forever begin
            @(negedge clk);
            if (rst || !rsp_valid) seen = 0;
            else if (!seen) begin
                seen = 1;
                if (sb_q.size() == 0) check("unexpected_rsp", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_out", rsp_out, e.out);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected below 50000", cyc);
        $fatal(1);
    end

    initial begin
        bit got;
        exp_t e;

        req0_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_out", rsp_out, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_opcode", alsu_opcode, OR);
        check("rst_flags", {alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_direction,
                            alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B}, 0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        issue(0, mk(ADD, 3, 2, 1, 0, 0, 0, 0, 0, 0, 6'b0, 3'd0), 6'sd6, 0, 1);
        issue(1, mk(MULT, -4, 3, 0, 0, 0, 0, 0, 0, 0, 6'b0, 3'd0), 6'b110100, 0, 1);
        issue(0, mk(SHIFT, 0, 0, 0, 1, 0, 0, 0, 0, 1, 6'b000101, 3'd2), 6'b010111, 0, 1);
        issue(1, mk(ROTATE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100001, 3'd1), 6'b110000, 0, 1);
        issue(0, mk(SHIFT, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000001, 3'd0), 6'b000010, 0, 1);
        issue(1, mk(INVALID_6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 6'b0, 3'd0), 6'sd0, 1, 1);
        issue(0, mk(ADD, 1, 1, 0, 0, 1, 0, 0, 0, 0, 6'b0, 3'd0), 6'sd0, 1, 1);
        issue(1, mk(OR, -3, 2, 0, 0, 0, 0, 1, 0, 0, 6'b0, 3'd0), -6'sd3, 0, 1);
        drain();

        // Consumer stall with a competing request pending.
        rsp_ready = 1'b0;
        issue(0, mk(ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, 6'b0, 3'd0), 6'sd3, 0, 1);
        req1_cmd   = mk(XOR, 1, 2, 0, 0, 0, 0, 0, 0, 0, 6'b0, 3'd0);
        req1_valid = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        if (!got) check("stall_rsp_timeout", 0, 1);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_out", rsp_out, 3);
            check("stall_id", rsp_id, 0);
            check("stall_req0_ready", req0_ready, 0);
            check("stall_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        drain();

        // Round-robin from a fresh reset with both requesters always valid.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req0_cmd = mk(ADD, 1, 1, 0, 0, 0, 0, 0, 0, 0, 6'b0, 3'd0);
        req1_cmd = mk(MULT, 2, 2, 0, 0, 0, 0, 0, 0, 0, 6'b0, 3'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) got = 1;
            end
            if (!got) check("rr_timeout", 0, 1);
            else begin
                check("rr_grant", req1_ready, k % 2);
                check("rr_onehot", req0_ready ^ req1_ready, 1);
                e.id = 1'(k % 2); e.out = (k % 2 == 1) ? 6'sd4 : 6'sd2; e.err = 0; e.cyc = cyc + 4;
                sb_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Reset in the middle of the seed sequence aborts without a response.
        issue(0, mk(SHIFT, 0, 0, 0, 1, 0, 0, 0, 0, 1, 6'b101010, 3'd3), 6'sd0, 0, 0);
        @(negedge clk);
        check("seed_busy", busy, 1);
        check("seed_opcode", alsu_opcode, SHIFT);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_opcode", alsu_opcode, OR);
        check("abort_flags", {alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_direction,
                              alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B}, 0);
        repeat (20) @(negedge clk);
        check("abort_no_rsp", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
